// File: rtl/powlib_upsizer_pkg.sv
// Shared helpers for the powlib width-conversion blocks.
package powlib_upsizer_pkg;

   // Ceiling log2, clamped to 1 so a single-lane index still has a bit.
   function automatic int powlib_clogb2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/powlib_upsizer.sv
// Width upsizer: packs N consecutive W-bit words into one W*N-bit beat,
// with an early flush on inlast that reports the filled lanes in outkeep.
module powlib_upsizer
   import powlib_upsizer_pkg::*;
#(
   parameter int W = 16,
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   indata,
   input  logic           invld,
   output logic           inrdy,
   input  logic           inlast,
   output logic [W*N-1:0] outdata,
   output logic           outvld,
   input  logic           outrdy,
   output logic [N-1:0]   outkeep,
   output logic           outlast
);

   logic [W*N-1:0] outdata_q;
   logic [N-1:0]   outkeep_q;
   logic           outlast_q;
   logic           outvld_q;
   logic           inacc;
   logic           outacc;

   // Ready depends only on the output stage, never on invld, so no upstream loop.
   assign inrdy  = rst && (!outvld_q || outrdy);
   assign inacc  = invld && inrdy;
   assign outacc = outvld_q && outrdy;

   assign outdata = outdata_q;
   assign outkeep = outkeep_q;
   assign outlast = outlast_q;
   assign outvld  = outvld_q;

   generate
      if (N > 1) begin : g_pack
         localparam int            IW       = powlib_clogb2(N);
         localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

         logic [IW-1:0]  idx_q;
         logic [W*N-1:0] acc_q;
         logic [W*N-1:0] acc_d;
         logic [W*N-1:0] beat_d;
         logic [N-1:0]   kacc_q;
         logic [N-1:0]   kacc_d;
         logic           complete;

         assign complete = inlast || (idx_q == LAST_IDX);

         always_comb begin
            // NOTE: every variable gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
            acc_d  = acc_q;
            kacc_d = kacc_q;
            beat_d = '0;
            for (int k = 0; k < N; k++) begin
               if (k == int'(idx_q)) begin
                  acc_d[k*W +: W] = indata;
                  kacc_d[k]       = 1'b1;
               end
               if (k <= int'(idx_q)) beat_d[k*W +: W] = acc_d[k*W +: W];
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            // NOTE: the accumulator is a plain register, not a RAM, so resetting it is cheap and stops a truncated packet leaking into the next beat.
            if (!rst) begin
               idx_q     <= '0;
               acc_q     <= '0;
               kacc_q    <= '0;
               outdata_q <= '0;
               outkeep_q <= '0;
               outlast_q <= 1'b0;
               outvld_q  <= 1'b0;
            end else begin
               // NOTE: non-blocking assignments let the later completion write override this drain, so a new beat replaces the old one with no bubble.
               if (outacc) outvld_q <= 1'b0;
               if (inacc) begin
                  if (complete) begin
                     outdata_q <= beat_d;
                     outkeep_q <= kacc_d;
                     outlast_q <= inlast;
                     outvld_q  <= 1'b1;
                     idx_q     <= '0;
                     acc_q     <= '0;
                     kacc_q    <= '0;
                  end else begin
                     acc_q  <= acc_d;
                     kacc_q <= kacc_d;
                     idx_q  <= idx_q + IW'(1);
                  end
               end
            end
         end
      end else begin : g_slice
         // Single lane: every accepted word completes, giving a one-deep register slice.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               outdata_q <= '0;
               outkeep_q <= '0;
               outlast_q <= 1'b0;
               outvld_q  <= 1'b0;
            end else if (inacc) begin
               outdata_q <= indata;
               outkeep_q <= '1;
               outlast_q <= inlast;
               outvld_q  <= 1'b1;
            end else if (outacc) begin
               outvld_q <= 1'b0;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_powlib_upsizer.sv
// Directed bench for powlib_upsizer: a W=8/N=4 packer and a W=16/N=1 slice,
// each checked against a scoreboard of beats predicted from the driven words.
module tb_powlib_upsizer;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } beat4_t;

   typedef struct packed {
      logic [15:0] data;
      logic        last;
   } beat1_t;

   logic clk;
   logic rst;

   logic [7:0]  indata4;
   logic        invld4, inrdy4, inlast4;
   logic [31:0] outdata4;
   logic        outvld4, outrdy4, outlast4;
   logic [3:0]  outkeep4;

   logic [15:0] indata1;
   logic        invld1, inrdy1, inlast1;
   logic [15:0] outdata1;
   logic        outvld1, outrdy1, outlast1;
   logic [0:0]  outkeep1;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit run1     = 0;

   beat4_t q4[$];
   beat1_t q1[$];

   logic [31:0] m_acc;
   logic [3:0]  m_keep;
   int          m_idx;

   powlib_upsizer #(.W(8), .N(4)) u_dut4 (
      .clk     (clk),
      .rst     (rst),
      .indata  (indata4),
      .invld   (invld4),
      .inrdy   (inrdy4),
      .inlast  (inlast4),
      .outdata (outdata4),
      .outvld  (outvld4),
      .outrdy  (outrdy4),
      .outkeep (outkeep4),
      .outlast (outlast4)
   );

   powlib_upsizer #(.W(16), .N(1)) u_dut1 (
      .clk     (clk),
      .rst     (rst),
      .indata  (indata1),
      .invld   (invld1),
      .inrdy   (inrdy1),
      .inlast  (inlast1),
      .outdata (outdata1),
      .outvld  (outvld1),
      .outrdy  (outrdy1),
      .outkeep (outkeep1),
      .outlast (outlast1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model4_clear();
      m_acc  = '0;
      m_keep = '0;
      m_idx  = 0;
   endtask

   // Independent packing model: lanes fill from 0, a flush pushes what is filled.
   task automatic model4_accept(input logic [7:0] d, input logic l);
      m_acc[m_idx*8 +: 8] = d;
      m_keep[m_idx]       = 1'b1;
      if (m_idx == 3 || l) begin
         q4.push_back('{data: m_acc, keep: m_keep, last: l});
         model4_clear();
      end else begin
         m_idx++;
      end
   endtask

   // Entered and left at posedge+1; invld4 stays high so words can follow back to back.
   task automatic send4(input logic [7:0] d, input logic l);
      bit ok;
      ok      = 1'b0;
      invld4  = 1'b1;
      indata4 = d;
      inlast4 = l;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         ok = inrdy4;
         step();
      end
      check("send4_accepted", 64'(ok), 64'd1);
      if (ok) model4_accept(d, l);
   endtask

   task automatic send1(input logic [15:0] d, input logic l);
      bit ok;
      ok      = 1'b0;
      invld1  = 1'b1;
      indata1 = d;
      inlast1 = l;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         ok = inrdy1;
         step();
      end
      check("send1_accepted", 64'(ok), 64'd1);
      if (ok) q1.push_back('{data: d, last: l});
   endtask

   always @(negedge clk) begin
      beat4_t e4;
      beat1_t e1;
      if (rst && outvld4 && outrdy4) begin
         check("q4_nonempty_at_beat", 64'(q4.size() != 0), 64'd1);
         if (q4.size() != 0) begin
            e4 = q4.pop_front();
            check("sb4_data", 64'(outdata4), 64'(e4.data));
            check("sb4_keep", 64'(outkeep4), 64'(e4.keep));
            check("sb4_last", 64'(outlast4), 64'(e4.last));
         end
      end
      if (rst && outvld1 && outrdy1) begin
         check("q1_nonempty_at_beat", 64'(q1.size() != 0), 64'd1);
         if (q1.size() != 0) begin
            e1 = q1.pop_front();
            check("sb1_data", 64'(outdata1), 64'(e1.data));
            check("sb1_keep", 64'(outkeep1), 64'd1);
            check("sb1_last", 64'(outlast1), 64'(e1.last));
         end
      end
   end

   initial begin
      outrdy1 = 1'b1;
      forever begin
         step();
         outrdy1 = run1 ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      int c0;
      logic [15:0] d;
      logic        l;

      rst     = 1'b0;
      indata4 = '0; invld4 = 1'b0; inlast4 = 1'b0; outrdy4 = 1'b1;
      indata1 = '0; invld1 = 1'b0; inlast1 = 1'b0;
      model4_clear();

      #3;
      check("rst_outvld4",  64'(outvld4),  64'd0);
      check("rst_outdata4", 64'(outdata4), 64'd0);
      check("rst_outkeep4", 64'(outkeep4), 64'd0);
      check("rst_outlast4", 64'(outlast4), 64'd0);
      check("rst_inrdy4",   64'(inrdy4),   64'd0);
      check("rst_outvld1",  64'(outvld1),  64'd0);
      check("rst_inrdy1",   64'(inrdy1),   64'd0);
      @(negedge clk);
      rst = 1'b1;
      step();

      // Four back-to-back words form one full beat, visible for exactly one cycle.
      c0 = cyc;
      send4(8'h11, 1'b0);
      send4(8'h22, 1'b0);
      send4(8'h33, 1'b0);
      send4(8'h44, 1'b0);
      invld4 = 1'b0;
      check("t1_no_stall", 64'(cyc - c0), 64'd4);
      @(negedge clk);
      check("t1_outvld",  64'(outvld4),  64'd1);
      check("t1_outdata", 64'(outdata4), 64'h44332211);
      check("t1_outkeep", 64'(outkeep4), 64'hF);
      check("t1_outlast", 64'(outlast4), 64'd0);
      step();
      @(negedge clk);
      check("t1_outvld_drop", 64'(outvld4), 64'd0);
      step();

      // Sustained stream: 16 words in 16 cycles, four beats with no bubble.
      c0 = cyc;
      for (int i = 0; i < 16; i++) send4(8'(i), 1'b0);
      invld4 = 1'b0;
      check("t2_stream_cycles", 64'(cyc - c0), 64'd16);
      step();
      step();

      // Early flush on the second word, then the next word restarts at lane 0.
      send4(8'hA1, 1'b0);
      send4(8'hA2, 1'b1);
      invld4 = 1'b0;
      @(negedge clk);
      check("t3_flush_data", 64'(outdata4), 64'h0000A2A1);
      check("t3_flush_keep", 64'(outkeep4), 64'h3);
      check("t3_flush_last", 64'(outlast4), 64'd1);
      step();
      send4(8'hB0, 1'b0);
      send4(8'hB1, 1'b0);
      send4(8'hB2, 1'b0);
      send4(8'hB3, 1'b0);
      invld4 = 1'b0;
      @(negedge clk);
      check("t3_next_data", 64'(outdata4), 64'hB3B2B1B0);
      check("t3_next_keep", 64'(outkeep4), 64'hF);
      step();

      // Backpressure: a pending beat holds steady and blocks input for 5 cycles.
      outrdy4 = 1'b0;
      send4(8'hC0, 1'b0);
      send4(8'hC1, 1'b0);
      send4(8'hC2, 1'b0);
      send4(8'hC3, 1'b0);
      indata4 = 8'hEE;
      inlast4 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_hold_vld",   64'(outvld4),  64'd1);
         check("t4_hold_data",  64'(outdata4), 64'hC3C2C1C0);
         check("t4_hold_keep",  64'(outkeep4), 64'hF);
         check("t4_hold_inrdy", 64'(inrdy4),   64'd0);
         step();
      end
      outrdy4 = 1'b1;
      @(negedge clk);
      check("t4_release_inrdy", 64'(inrdy4), 64'd1);
      model4_accept(8'hEE, 1'b0);
      step();
      send4(8'hEF, 1'b0);
      invld4 = 1'b0;

      // Asynchronous reset mid-cycle drops the two-word partial beat.
      #2;
      rst = 1'b0;
      #1;
      check("t5_rst_outvld",  64'(outvld4),  64'd0);
      check("t5_rst_outdata", 64'(outdata4), 64'd0);
      check("t5_rst_outkeep", 64'(outkeep4), 64'd0);
      check("t5_rst_outlast", 64'(outlast4), 64'd0);
      check("t5_rst_inrdy",   64'(inrdy4),   64'd0);
      model4_clear();
      q4.delete();
      @(negedge clk);
      rst = 1'b1;
      step();
      send4(8'h51, 1'b0);
      send4(8'h52, 1'b0);
      send4(8'h53, 1'b0);
      send4(8'h54, 1'b0);
      invld4 = 1'b0;
      @(negedge clk);
      check("t5_after_data", 64'(outdata4), 64'h54535251);
      check("t5_after_keep", 64'(outkeep4), 64'hF);
      step();

      // N=1 slice under random valid and ready.
      run1 = 1'b1;
      for (int i = 0; i < 200; i++) begin
         d = 16'($urandom_range(0, 65535));
         l = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0) begin
            invld1  = 1'b0;
            indata1 = 16'($urandom_range(0, 65535));
            step();
         end
         send1(d, l);
      end
      invld1 = 1'b0;
      run1   = 1'b0;
      for (int t = 0; t < 50 && q1.size() != 0; t++) step();
      check("t6_q1_drained", 64'(q1.size()), 64'd0);
      check("q4_drained",    64'(q4.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
